conv_window_ctrl: RTL

- Parametrised successor to the convolver control path.
- Tracks a raster-streamed image, one pixel per accepted beat, and strobes `enable` when the K×K window ending at the current pixel is complete and lies on the stride grid.
- Adds rectangular images, configurable stride, input-valid stalling, output coordinates and an end-of-frame pulse.
- Sits between the pixel source and the convolver datapath/line buffers.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_axis_counter.sv | 52 +++++
 rtl/conv_window_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the convolution window controller: width math, output-map
// dimensions and the elaboration-time parameter legality check.
package conv_pkg;

  // Ceiling log2, clamped to 1 so that degenerate sizes still give a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int out_dim(input int len, input int k, input int s);
    return (len - k) / s + 1;
  endfunction

  function automatic bit params_ok(input int k, input int w, input int h, input int s);
    return (k >= 1) && (k <= w) && (k <= h) && (s >= 1);
  endfunction

endpackage

// File: rtl/conv_axis_counter.sv
// One image axis: wrapping position counter plus a stride-phase counter that
// starts once the position reaches the first full window.
module conv_axis_counter
  import conv_pkg::*;
#(
  parameter int LENGTH = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic wrap,
  output logic hit
);

  localparam int PW = clog2(LENGTH);
  localparam int SW = clog2(STRIDE);

  logic [PW-1:0] pos_q, pos_d;
  logic [SW-1:0] ph_q, ph_d;

  assign wrap = step && (pos_q == PW'(LENGTH - 1));
  assign hit  = (pos_q >= PW'(K - 1)) && (ph_q == '0);

  always_comb begin
    pos_d = pos_q;
    ph_d  = ph_q;
    if (step) begin
      if (wrap) begin
        pos_d = '0;
        ph_d  = '0;
      end else begin
        pos_d = pos_q + 1'b1;
        // Phase only moves from the first complete window onwards, so it is 0 there.
        if (pos_q >= PW'(K - 1))
          ph_d = (ph_q == SW'(STRIDE - 1)) ? '0 : ph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      ph_q  <= '0;
    end else begin
      pos_q <= pos_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-stream window tracker: strobes enable (one cycle late) for every KxK
// window on the stride grid, with output-map coordinates and frame status.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int STRIDE       = 1,
  localparam int OUT_W = out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE),
  localparam int OUT_H = out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE),
  localparam int CW    = clog2(OUT_W),
  localparam int RW    = clog2(OUT_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          enable,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          frame_done,
  output logic          busy
);

  // Output counters must be able to hold OUT_W/OUT_H once the last window is taken.
  localparam int OCW = clog2(OUT_W + 1);
  localparam int ORW = clog2(OUT_H + 1);

  if (!params_ok(KERNEL_SIZE, IMAGE_WIDTH, IMAGE_HEIGHT, STRIDE)) begin : g_bad_params
    $error("conv_window_ctrl: illegal KERNEL_SIZE/IMAGE/STRIDE combination");
  end

  logic col_wrap, col_hit, row_wrap, row_hit;

  conv_axis_counter #(.LENGTH(IMAGE_WIDTH), .K(KERNEL_SIZE), .STRIDE(STRIDE)) u_col (
    .clk(clk), .reset(reset), .step(in_valid), .wrap(col_wrap), .hit(col_hit)
  );

  conv_axis_counter #(.LENGTH(IMAGE_HEIGHT), .K(KERNEL_SIZE), .STRIDE(STRIDE)) u_row (
    .clk(clk), .reset(reset), .step(col_wrap), .wrap(row_wrap), .hit(row_hit)
  );

  logic [OCW-1:0] oc_q, oc_d;
  logic [ORW-1:0] or_q, or_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           en_q, en_d, fd_q, fd_d, busy_q, busy_d;
  logic           hit, row_last_hit;

  assign hit = in_valid && col_hit && row_hit &&
               (oc_q < OCW'(OUT_W)) && (or_q < ORW'(OUT_H));
  assign row_last_hit = hit && (oc_q == OCW'(OUT_W - 1));

  always_comb begin
    oc_d   = oc_q;
    or_d   = or_q;
    col_d  = col_q;
    row_d  = row_q;
    busy_d = busy_q;
    en_d   = hit;
    fd_d   = row_last_hit && (or_q == ORW'(OUT_H - 1));
    if (hit) begin
      oc_d  = oc_q + 1'b1;
      col_d = oc_q[CW-1:0];
      row_d = or_q[RW-1:0];
    end
    if (row_last_hit) or_d = or_q + 1'b1;
    if (col_wrap)     oc_d = '0;
    if (row_wrap)     or_d = '0;
    // row_wrap only fires on the final pixel of the frame.
    if (in_valid)     busy_d = !row_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oc_q   <= '0;
      or_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      en_q   <= 1'b0;
      fd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      oc_q   <= oc_d;
      or_q   <= or_d;
      col_q  <= col_d;
      row_q  <= row_d;
      en_q   <= en_d;
      fd_q   <= fd_d;
      busy_q <= busy_d;
    end
  end

  assign enable     = en_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule
